delta_sigma_demodulator: RTL and testbench
==========================================

# delta_sigma_demodulator

Receive-side counterpart of the delta-sigma PWM modulator: takes the 1-bit pulse stream (`pwm_out` looped back, or an external pin), low-pass filters and decimates it with a CIC (sinc^ORDER) filter, and delivers reconstructed multi-bit samples over a valid/ready handshake. Used for on-chip loopback checking of the DAC and as a bitstream-to-PCM decoder. Integrators run at the bit rate; the comb section is time-multiplexed over one shared subtractor by a small state machine.

## Interface
- `ORDER`, 3: CIC order, 1..4.
- `DECIM_LOG2`, 4: log2 of the decimation ratio DECIM; must satisfy 2^DECIM_LOG2 > ORDER+1.
- `OUT_BITS`, ORDER*DECIM_LOG2+1: output/accumulator width W; derived, do not override.
- Reset: **one clock; reset is asynchronous and active-low.**
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  bit strobe; `bit_in` is consumed on clock edges with `en`=1.
- `bit_in`  in  1  pulse-stream bit.
- `y`  out  W  decoded sample, unsigned 0..DECIM^ORDER (signed, see Configuration).
- `y_valid`  out  1  `y` holds an unconsumed sample.
- `y_ready`  in  1  consumer accepts `y` when `y_valid`&&`y_ready`.
- `overrun`  out  1  sticky: a sample was overwritten before acceptance.

## Operation
- Integrators I1..I_ORDER, W bits, wrap mod 2^W. On `en`: I1 += `bit_in`, Ik += I(k-1) (previous-cycle value, i.e. pipelined chain).
- Decimation counter `phase` (DECIM_LOG2 bits) increments on `en`, wraps DECIM-1 -> 0. On the `en` edge where `phase`==DECIM-1: snapshot I_ORDER (post-update) into work register `c`, start comb.
- FSM states: IDLE, COMB (sub-index s = 0..ORDER-1), OUT.
  - IDLE -> COMB(0) on snapshot.
  - COMB(s): `c` <= `c` - D[s], D[s] <= `c` (one subtraction per clock, independent of `en`); COMB(ORDER-1) -> OUT.
  - OUT: `y` <= `c`, `y_valid` <= 1; if `y_valid` was already 1 and not being accepted this cycle, `overrun` <= 1. -> IDLE.
- Comb arithmetic is mod 2^W; results are exact in 0..2^(W-1).
- Delay registers D[0..ORDER-1] start at 0; outputs 0..ORDER-2 after reset are transient, output ORDER-1 onward exact.
- Handshake: `y_valid` drops on the edge where `y_valid`&&`y_ready`, unless OUT loads a new sample on the same edge (then stays 1, `y` updates, no overrun).
- `en`=0 freezes integrators and `phase` only; a running comb sequence completes.

## Timing
- Reset values: all integrators, D[], `c`, `phase`, `y` = 0; FSM = IDLE; `y_valid` = 0; `overrun` = 0.
- Latency: last bit of a period accepted at edge E; `y_valid`/`y` update at edge E+ORDER+1.
- Since DECIM > ORDER+1 bit edges, a new snapshot never arrives while COMB/OUT is active.
- `rst_n` low mid-comb: aborts immediately, all state to reset values; no partial sample emitted.
- `y_ready` is ignored while `y_valid`=0.

## Configuration
- `DS_DEMOD_SIGNED_OUT_EN` defined: OUT loads `y` = `c` - 2^(W-2) as two's complement (zeros -> -2^(W-2), ones -> +2^(W-2), 50% density -> 0).
- Undefined: `y` is unsigned `c` as above. No other behaviour differs.

## Structure
- Shared package `delta_sigma_pkg`: `ds_demod_state_t` enum (IDLE, COMB, OUT), function `ds_demod_width(order, decim_log2)`.
- One sub-module: `cic_integrator_chain` (ORDER W-bit integrators, `en`, `bit_in`, output I_ORDER); comb/FSM/handshake stay in the top.

## Test plan (ORDER=3, DECIM_LOG2=4, W=13)
- Constant `bit_in`=0, `en`=1, `y_ready`=1 -> every `y`=0, `y_valid` pulses once per 16 cycles, `overrun`=0.
- Constant `bit_in`=1 -> outputs 0,1 transient; from 3rd output on `y`=4096; with `DS_DEMOD_SIGNED_OUT_EN` `y`=2048.
- Alternating 1,0 -> from 3rd output `y`=2048 (signed build: 0); `y_valid` rises exactly 4 edges after the 16th bit edge.
- `en` asserted every 3rd cycle, `bit_in`=1 -> same values as continuous case, one sample per 48 cycles.
- `y_ready`=0 across two periods -> `y_valid` stays 1, `y` updates to second sample, `overrun`=1 sticky until reset; asserting `y_ready` together with a new OUT edge -> no overrun.
- `rst_n` pulsed low during COMB(1) -> outputs/state all 0 at once, no `y_valid` for that period, next sample follows the transient sequence again.

Source files
------------

// File: rtl/delta_sigma_pkg.sv
// rtl/delta_sigma_pkg.sv - shared FSM state type and width helper for the delta-sigma demodulator
package delta_sigma_pkg;

  // Comb sequencer states: wait for a snapshot, walk the comb stages, publish the sample
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMB = 2'd1,
    OUT  = 2'd2
  } ds_demod_state_t;

  // Accumulator width that holds DECIM^ORDER without ambiguity
  function automatic int ds_demod_width(input int order, input int decim_log2);
    return order * decim_log2 + 1;
  endfunction

endpackage

// File: rtl/delta_sigma_demodulator_if.sv
// rtl/delta_sigma_demodulator_if.sv - decoded-sample valid/ready stream between demodulator and consumer
interface delta_sigma_demodulator_if #(
  parameter int W = 13
) ();

  logic [W-1:0] y;
  logic         y_valid;
  logic         y_ready;

  // The demodulator produces samples; the consumer accepts them
  modport master (
    output y,
    output y_valid,
    input  y_ready
  );

  modport slave (
    input  y,
    input  y_valid,
    output y_ready
  );

endinterface

// File: rtl/cic_integrator_chain.sv
// rtl/cic_integrator_chain.sv - pipelined chain of ORDER wrapping integrators running at the bit rate
module cic_integrator_chain #(
  parameter int ORDER = 3,
  parameter int W     = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] integ_out
);

  logic [W-1:0] integ_q [ORDER];
  logic [W-1:0] integ_d [ORDER];

  // Next integrator values: stage 0 adds the input bit, later stages add the previous stage's old value
  always_comb begin
    for (int k = 0; k < ORDER; k++) begin
      integ_d[k] = integ_q[k];
    end
    integ_d[0] = integ_q[0] + {{(W-1){1'b0}}, bit_in};
    for (int k = 1; k < ORDER; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  // Integrators advance only on bit strobes and wrap modulo 2^W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= integ_d[k];
      end
    end
  end

  // The top snapshots the last stage as it will be after this edge's update
  assign integ_out = integ_d[ORDER-1];

endmodule

// File: rtl/delta_sigma_demodulator.sv
// rtl/delta_sigma_demodulator.sv - CIC decimating decoder of a 1-bit pulse stream; DS_DEMOD_SIGNED_OUT_EN selects signed output
module delta_sigma_demodulator
  import delta_sigma_pkg::*;
#(
  parameter int ORDER      = 3,
  parameter int DECIM_LOG2 = 4,
  parameter int OUT_BITS   = ds_demod_width(ORDER, DECIM_LOG2)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      bit_in,
  delta_sigma_demodulator_if.master out,
  output logic                      overrun
);

  localparam int W  = OUT_BITS;
  localparam int SW = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam logic [SW-1:0] LAST_SUB = SW'(ORDER - 1);
`ifdef DS_DEMOD_SIGNED_OUT_EN
  localparam logic [W-1:0] MID_SCALE = {2'b01, {(W-2){1'b0}}};
`endif

  ds_demod_state_t       state_q;
  ds_demod_state_t       state_d;
  logic [SW-1:0]         sub_q;
  logic [SW-1:0]         sub_d;
  logic [DECIM_LOG2-1:0] phase_q;
  logic [W-1:0]          integ_out;
  logic [W-1:0]          c_q;
  logic [W-1:0]          d_sel;
  logic [W-1:0]          y_load;
  logic [W-1:0]          d_q [ORDER];
  logic                  snap;

  cic_integrator_chain #(
    .ORDER (ORDER),
    .W     (W)
  ) u_integ (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bit_in    (bit_in),
    .integ_out (integ_out)
  );

  // The last bit of each decimation period triggers a snapshot; the sequencer is always idle by then
  assign snap = en && (phase_q == {DECIM_LOG2{1'b1}}) && (state_q == IDLE);

  // Decimation phase counts bit strobes and wraps naturally at DECIM-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else if (en) begin
      phase_q <= phase_q + DECIM_LOG2'(1);
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sub_q   <= '0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
    end
  end

  // Sequencer next state: one comb stage per clock, regardless of the bit strobe
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    case (state_q)
      IDLE: begin
        if (snap) begin
          state_d = COMB;
          sub_d   = '0;
        end
      end
      COMB: begin
        if (sub_q == LAST_SUB) begin
          state_d = OUT;
          sub_d   = '0;
        end else begin
          sub_d = sub_q + SW'(1);
        end
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sub_d   = '0;
      end
    endcase
  end

  // Delay register feeding the shared subtractor for the current comb stage
  always_comb begin
    d_sel = '0;
    for (int k = 0; k < ORDER; k++) begin
      if (sub_q == SW'(k)) begin
        d_sel = d_q[k];
      end
    end
  end

  // Comb datapath: snapshot into c, then c <= c - D[s] while D[s] keeps the stage input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      for (int k = 0; k < ORDER; k++) begin
        d_q[k] <= '0;
      end
    end else if (snap) begin
      c_q <= integ_out;
    end else if (state_q == COMB) begin
      c_q <= c_q - d_sel;
      for (int k = 0; k < ORDER; k++) begin
        if (sub_q == SW'(k)) begin
          d_q[k] <= c_q;
        end
      end
    end
  end

`ifdef DS_DEMOD_SIGNED_OUT_EN
  // Re-centre around mid-scale so 50% density decodes to zero
  assign y_load = c_q - MID_SCALE;
`else
  assign y_load = c_q;
`endif

  // Output holding register: a fresh sample wins over acceptance; unaccepted overwrite is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out.y       <= '0;
      out.y_valid <= 1'b0;
      overrun     <= 1'b0;
    end else if (state_q == OUT) begin
      out.y       <= y_load;
      out.y_valid <= 1'b1;
      if (out.y_valid && !out.y_ready) begin
        overrun <= 1'b1;
      end
    end else if (out.y_valid && out.y_ready) begin
      out.y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delta_sigma_demodulator.sv
// tb/tb_delta_sigma_demodulator.sv - directed and random checks of the demodulator against a prefix-sum reference
module tb_delta_sigma_demodulator;

  localparam int ORDER = 3;
  localparam int DL    = 4;
  localparam int DECIM = 16;
  localparam int W     = 13;
`ifdef DS_DEMOD_SIGNED_OUT_EN
  localparam int SOFF = 2048;
`else
  localparam int SOFF = 0;
`endif
  localparam logic [W-1:0] EXP_FIRST  = W'(560 - SOFF);
  localparam logic [W-1:0] EXP_SECOND = W'(3280 - SOFF);
  localparam logic [W-1:0] EXP_ONES   = W'(4096 - SOFF);
  localparam logic [W-1:0] EXP_ALT    = W'(2048 - SOFF);

  typedef struct {
    int           due;
    logic [W-1:0] val;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic bit_in;
  logic overrun;

  delta_sigma_demodulator_if #(.W(W)) dif ();

  delta_sigma_demodulator #(
    .ORDER      (ORDER),
    .DECIM_LOG2 (DL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .bit_in  (bit_in),
    .out     (dif),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int           vectors     = 0;
  int           miscompares = 0;
  int           edge_cnt    = 0;
  bit           hist[$];
  longint       snaps[$];
  pend_t        pend[$];
  logic         m_valid;
  logic [W-1:0] m_y;
  logic         m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Last integrator after n bits: iterated prefix sums of the bit history
  function automatic longint i_order(input int n);
    longint cur[$];
    longint nxt[$];
    longint acc = 0;
    for (int m = 0; m <= n; m++) begin
      cur.push_back(acc);
      if (m < n) acc += longint'(hist[m]);
    end
    for (int k = 2; k <= ORDER; k++) begin
      nxt = {};
      acc = 0;
      for (int m = 0; m <= n; m++) begin
        nxt.push_back(acc);
        acc += cur[m];
      end
      cur = nxt;
    end
    return cur[n];
  endfunction

  // Output k: ORDER-th backward difference of snapshots, zero before reset
  function automatic logic [W-1:0] out_value(input int k);
    longint acc = 0;
    for (int j = 0; j <= ORDER; j++) begin
      if (k - j >= 0) acc += ((j % 2) ? -1 : 1) * binom(ORDER, j) * snaps[k-j];
    end
    acc -= SOFF;
    return acc[W-1:0];
  endfunction

  task automatic model_reset();
    hist.delete();
    snaps.delete();
    pend.delete();
    m_valid = 1'b0;
    m_y     = '0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic b, input logic r);
    logic  vb;
    pend_t p;
    edge_cnt++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    vb = m_valid;
    if (pend.size() > 0 && pend[0].due == edge_cnt) begin
      p = pend.pop_front();
      if (vb && !r) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_y     = p.val;
    end else if (vb && r) begin
      m_valid = 1'b0;
    end
    if (e) begin
      hist.push_back(b);
      if (hist.size() % DECIM == 0) begin
        snaps.push_back(i_order(hist.size()));
        p.due = edge_cnt + ORDER + 1;
        p.val = out_value(snaps.size() - 1);
        pend.push_back(p);
      end
    end
  endtask

  task automatic check_outputs();
    chk("y_valid", {31'd0, dif.y_valid}, {31'd0, m_valid});
    chk("y", {19'd0, dif.y}, {19'd0, m_y});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
  endtask

  task automatic step(input logic e, input logic b, input logic r);
    @(negedge clk);
    en          = e;
    bit_in      = b;
    dif.y_ready = r;
    @(posedge clk);
    #1;
    model_edge(e, b, r);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    int found;
    rst_n       = 1'b0;
    en          = 1'b0;
    bit_in      = 1'b0;
    dif.y_ready = 1'b0;
    model_reset();

    // Reset state
    do_reset();
    chk("reset_y", {19'd0, dif.y}, 32'd0);

    // All zeros
    for (int i = 0; i < 5 * DECIM; i++) step(1'b1, 1'b0, 1'b1);

    // All ones from reset: transients then full scale
    do_reset();
    for (int i = 0; i < 5 * DECIM + ORDER + 1; i++) step(1'b1, 1'b1, 1'b1);
    chk("ones_steady", {19'd0, dif.y}, {19'd0, EXP_ONES});

    // Alternating 1,0: latency of exactly ORDER+1 edges after the last bit
    do_reset();
    for (int i = 0; i < 3 * DECIM; i++) step(1'b1, (i % 2) == 0, 1'b1);
    for (int i = 0; i < ORDER; i++) step(1'b1, (i % 2) == 0, 1'b1);
    chk("alt_not_early", {31'd0, dif.y_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b1);
    chk("alt_valid", {31'd0, dif.y_valid}, 32'd1);
    chk("alt_value", {19'd0, dif.y}, {19'd0, EXP_ALT});

    // Sparse bit strobe: every third cycle
    do_reset();
    for (int i = 0; i < 4 * 3 * DECIM + ORDER + 1; i++) step((i % 3) == 2, 1'b1, 1'b1);
    chk("sparse_valid", {31'd0, dif.y_valid}, 32'd1);
    chk("sparse_value", {19'd0, dif.y}, {19'd0, EXP_ONES});

    // Back-pressure: accept exactly on a reload edge, then overwrite, then sticky overrun
    do_reset();
    for (int i = 0; i < DECIM + ORDER + 1; i++) step(1'b1, 1'b1, 1'b0);
    chk("bp_first", {19'd0, dif.y}, {19'd0, EXP_FIRST});
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (pend.size() > 0 && pend[0].due == edge_cnt + 1) found = 1;
      else step(1'b1, 1'b1, 1'b0);
    end
    chk("bp_reach_reload", found, 1);
    step(1'b1, 1'b1, 1'b1);
    chk("bp_coincide_valid", {31'd0, dif.y_valid}, 32'd1);
    chk("bp_coincide_value", {19'd0, dif.y}, {19'd0, EXP_SECOND});
    chk("bp_coincide_no_ovr", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < DECIM; i++) step(1'b1, 1'b1, 1'b0);
    chk("bp_overrun", {31'd0, overrun}, 32'd1);
    for (int i = 0; i < 2 * DECIM; i++) step(1'b1, 1'b1, 1'b1);
    chk("bp_sticky", {31'd0, overrun}, 32'd1);

    // Reset while the comb is in its second stage
    do_reset();
    for (int i = 0; i < 2 * DECIM + 8; i++) step(1'b1, 1'b1, 1'b1);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (pend.size() > 0 && pend[0].due == edge_cnt + ORDER) found = 1;
      else step(1'b1, 1'b1, 1'b1);
    end
    chk("mid_reach_comb1", found, 1);
    do_reset();
    chk("mid_no_valid", {31'd0, dif.y_valid}, 32'd0);
    for (int i = 0; i < DECIM + ORDER + 1; i++) step(1'b1, 1'b1, 1'b1);
    chk("mid_restart", {19'd0, dif.y}, {19'd0, EXP_FIRST});

    // Random bits, strobes and back-pressure
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
